seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one combinational 4-bit-to-7-segment decoder across a 4-digit common-anode display. It holds a 16-bit display word and, for each digit in turn, drives that digit's nibble to the shared decoder. It also drives that digit's active-low anode, with a blanking guard before each digit to suppress ghosting. Writes from the datapath (e.g. decoded/corrected Hamming data) are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller driving one shared 7-segment decoder.
// Optional leading-zero suppression is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  bin,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);

  localparam int unsigned CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GEND = CW'(GUARD_CYCLES - 1);

  typedef enum logic {GUARD, ON} state_t;

  // Handshake: wr_en is a single-cycle strobe with no ready; every strobe is accepted.
  state_t          state, state_n;
  logic [1:0]      digit, digit_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [15:0]     shown, shown_n;
  logic [15:0]     shadow, shadow_n;
  logic            pending_n;
  logic [3:0]      bin_n, an_n;
  logic            frame_tick_n;
  logic            boundary;
  logic            lz_dark;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GUARD;
      digit      <= 2'd0;
      cnt        <= '0;
      shown      <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      bin        <= 4'h0;
      an         <= 4'b1111;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      digit      <= digit_n;
      cnt        <= cnt_n;
      shown      <= shown_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      bin        <= bin_n;
      an         <= an_n;
      frame_tick <= frame_tick_n;
    end
  end

  always_comb begin
    state_n   = state;
    digit_n   = digit;
    cnt_n     = cnt;
    shown_n   = shown;
    shadow_n  = shadow;
    pending_n = pending;
    boundary  = (cnt == CNT_LAST) && (digit == 2'd3);
    lz_dark   = 1'b0;

    if (!en) begin
      // Disabled: park at digit 0 guard and let writes land straight in the display word.
      state_n   = GUARD;
      digit_n   = 2'd0;
      cnt_n     = '0;
      pending_n = 1'b0;
      if (wr_en) begin
        shown_n  = wr_data;
        shadow_n = wr_data;
      end else if (pending) begin
        shown_n = shadow;
      end
    end else begin
      if (cnt == CNT_LAST) begin
        cnt_n   = '0;
        state_n = GUARD;
        digit_n = digit + 2'd1;
      end else begin
        cnt_n = cnt + CW'(1);
        if (state == GUARD && cnt == CNT_GEND) state_n = ON;
      end

      if (wr_en && boundary) begin
        shown_n   = wr_data;
        pending_n = 1'b0;
      end else if (wr_en) begin
        shadow_n  = wr_data;
        pending_n = 1'b1;
      end else if (boundary && pending) begin
        shown_n   = shadow;
        pending_n = 1'b0;
      end
    end

`ifdef SEG7_LZ_BLANK_EN
    case (digit_n)
      2'd3:    lz_dark = (shown_n[15:12] == 4'h0);
      2'd2:    lz_dark = (shown_n[15:8] == 8'h00);
      2'd1:    lz_dark = (shown_n[15:4] == 12'h000);
      default: lz_dark = 1'b0;
    endcase
`else
    lz_dark = 1'b0;
`endif

    // Outputs are computed from next-state values so bin and an move on the same edge.
    bin_n = shown_n[4*digit_n +: 4];
    if (state_n == ON && !blank_mask[digit_n] && !lz_dark)
      an_n = ~(4'b0001 << digit_n);
    else
      an_n = 4'b1111;
    frame_tick_n = en && (cnt_n == CNT_LAST) && (digit_n == 2'd3);
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl using a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int D = 8;
  localparam int G = 2;
  localparam int F = 4 * D;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  blank_mask;
  logic [3:0]  bin;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  seg7_scan_ctrl #(.DIGIT_CYCLES(D), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_data(wr_data),
    .blank_mask(blank_mask), .bin(bin), .an(an), .pending(pending),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  exp_q[$];
  int          n_vec;
  int          n_err;

  // Reference model: position within the frame plus the buffered words.
  int          m_pos;
  logic [15:0] m_shown;
  logic [15:0] m_shadow;
  logic        m_pend;

  function automatic logic [9:0] model_out();
    int slot;
    int off;
    logic dark;
    logic [3:0] a;
    logic [15:0] w;
    slot = m_pos / D;
    off  = m_pos % D;
    dark = blank_mask[slot];
`ifdef SEG7_LZ_BLANK_EN
    w = m_shown >> (4 * slot);
    if (slot > 0 && w == 16'h0000) dark = 1'b1;
`else
    w = 16'h0000;
`endif
    a = 4'b1111;
    if (off >= G && !dark) a = ~(4'b0001 << slot);
    return {a, m_shown[4*slot +: 4], m_pend, (m_pos == F - 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got an=%b bin=%h pend=%b tick=%b, expected an=%b bin=%h pend=%b tick=%b",
               tag, $time, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Applies the current inputs to the model for the coming edge, then checks after it.
  task automatic step();
    logic [9:0] e;
    if (!en) begin
      m_pos = 0;
      if (wr_en) m_shown = wr_data;
      else if (m_pend) m_shown = m_shadow;
      m_pend = 1'b0;
    end else begin
      if (wr_en && m_pos == F - 1) begin
        m_shown = wr_data;
        m_pend  = 1'b0;
      end else if (wr_en) begin
        m_shadow = wr_data;
        m_pend   = 1'b1;
      end else if (m_pos == F - 1 && m_pend) begin
        m_shown = m_shadow;
        m_pend  = 1'b0;
      end
      m_pos = (m_pos + 1) % F;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("scan", {an, bin, pending, frame_tick}, e);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pos    = 0;
    m_shown  = 16'h0000;
    m_shadow = 16'h0000;
    m_pend   = 1'b0;
    exp_q.delete();
    check("reset", {an, bin, pending, frame_tick}, 10'b1111_0000_0_0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; blank_mask = 4'b0000;
    @(negedge clk);
    en = 1'b1;
    do_reset();

    // Idle scan of an all-zero word across two frames.
    run(2 * F + 3);

    // Write at cycle 5 after reset, shown from the next frame on.
    do_reset();
    run(5);
    write(16'hA5C3);
    run(2 * F);

    // Last write in a frame wins.
    write(16'h1111);
    run(3);
    write(16'h2222);
    run(F + 10);

    // Write exactly on the frame boundary commits without pending.
    while (m_pos != F - 1) step();
    write(16'h7E81);
    run(F + 4);

    // Live blank mask on digit 2.
    blank_mask = 4'b0100;
    run(F + 5);
    blank_mask = 4'b0000;

    // Leading-zero candidate word.
    write(16'h0042);
    run(2 * F);

    // Disable mid-frame with a pending word and a write while dark.
    while (m_pos != D + 3) step();
    write(16'h4444);
    en = 1'b0;
    run(2);
    write(16'h3333);
    run(2);
    en = 1'b1;
    run(F + 6);

    // Random writes and masks.
    repeat (300) begin
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) write(16'($urandom_range(0, 65535)));
      else step();
    end
    blank_mask = 4'b0000;

    // Asynchronous reset in the middle of an ON slot with a nonzero nibble showing.
    write(16'hBEEF);
    run(F);
    while (m_pos % D != G + 2) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {an, bin, pending, frame_tick}, 10'b1111_0000_0_0);
    @(negedge clk);
    check("rst_hold", {an, bin, pending, frame_tick}, 10'b1111_0000_0_0);
    rst = 1'b0;
    m_pos    = 0;
    m_shown  = 16'h0000;
    m_shadow = 16'h0000;
    m_pend   = 1'b0;
    exp_q.delete();
    run(F + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
